if_stream_packer: RTL

- Upstream feeder for the IF buffer FIFO of the convolution top.
- Accepts a raw activation stream over a valid/ready handshake and tags each element with start-of-row and end-of-row bits, based on the configured row length and row count.
- Packs IF_PAR_WRITE tagged elements into one word and drives the IF FIFO write port, respecting IF_full back-pressure.
- Runs one frame (cfg_num_rows rows of cfg_row_len elements) per start pulse.

---
 rtl/if_stream_packer.sv | 86 ++++++++
 1 files changed

// File: rtl/if_stream_packer.sv
// if_stream_packer: tags a row-structured element stream and packs groups of lanes into IF FIFO words (option IF_PACK_PAD_FLUSH_EN)
module if_stream_packer #(
  parameter int DATA_WIDTH   = 8,
  parameter int IF_PAR_WRITE = 2,
  parameter int LEN_W        = 8
) (
  input  logic                                   clk,
  input  logic                                   rstn,
  input  logic                                   start,
  input  logic [LEN_W-1:0]                       cfg_row_len,
  input  logic [LEN_W-1:0]                       cfg_num_rows,
  input  logic                                   s_valid,
  input  logic [DATA_WIDTH-1:0]                  s_data,
  output logic                                   s_ready,
  input  logic                                   IF_full,
  output logic                                   IF_wen,
  output logic [IF_PAR_WRITE*(DATA_WIDTH+2)-1:0] IF_din,
  output logic                                   busy,
  output logic                                   done
);
  localparam int LW = DATA_WIDTH + 2;
  localparam int W  = IF_PAR_WRITE * LW;
  localparam int CW = IF_PAR_WRITE > 1 ? $clog2(IF_PAR_WRITE) : 1;
  typedef enum logic [1:0] {IDLE, FILL, PUSH, FIN} state_t;
  state_t state, nxt;
  logic [LEN_W-1:0] rl, nr, col, row;
  logic [CW-1:0] lane;
  logic last, cfg_ok, acc, eor, fin_el, grp_full, drop;
  logic [W-1:0] stage;
  // next-state decode and handshake outputs
  always_comb begin
    cfg_ok = |cfg_row_len && |cfg_num_rows;
    acc = state == FILL && s_valid;
    eor = col == rl - 1'b1;
    fin_el = eor && row == nr - 1'b1;
    grp_full = lane == CW'(IF_PAR_WRITE - 1);
`ifdef IF_PACK_PAD_FLUSH_EN
    drop = 1'b0;
`else
    drop = fin_el && !grp_full;
`endif
    s_ready = state == FILL;
    IF_wen = state == PUSH && !IF_full;
    busy = state != IDLE;
    done = state == FIN;
    IF_din = stage;
    nxt = state == IDLE ? (start ? (cfg_ok ? FILL : FIN) : IDLE)
        : state == FILL ? (!acc ? FILL : drop ? FIN : (grp_full || fin_el) ? PUSH : FILL)
        : state == PUSH ? (IF_full ? PUSH : last ? FIN : FILL)
        : IDLE;
  end
  // state, row/column/lane counters and the staging word
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      rl <= '0;
      nr <= '0;
      col <= '0;
      row <= '0;
      lane <= '0;
      last <= 1'b0;
      stage <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && start && cfg_ok) begin
        rl <= cfg_row_len;
        nr <= cfg_num_rows;
        col <= '0;
        row <= '0;
        lane <= '0;
        last <= 1'b0;
        stage <= '0;
      end
      if (acc) begin
        for (int i = 0; i < IF_PAR_WRITE; i++)
          if (lane == CW'(i)) stage[i*LW +: LW] <= {col == '0, eor, s_data};
        col <= eor ? '0 : col + 1'b1;
        row <= eor ? row + 1'b1 : row;
        lane <= (grp_full || fin_el) ? '0 : lane + 1'b1;
        last <= fin_el;
        if (drop) stage <= '0;
      end
      if (IF_wen) stage <= '0;
    end
  end
endmodule
